// File: rtl/bnn_ocr_pkg.sv
// Shared types and constants for the BNN OCR receive path.
//   img_rx_state_t : image receive FSM states
//   OP_LOAD        : opcode announcing an image payload
//   OP_CLEAR       : opcode clearing the image register
//   IMG_BITS_DEFAULT : default frame size in pixels (1 bit per pixel)
package bnn_ocr_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCheck,
    StReady
  } img_rx_state_t;

  localparam logic [7:0] OP_LOAD  = 8'hA5;
  localparam logic [7:0] OP_CLEAR = 8'h5A;

  localparam int unsigned IMG_BITS_DEFAULT = 1024;

endpackage

// File: rtl/byte_accept_gate.sv
// Byte handshake towards the SPI receive stage.
// The SPI stage keeps byte_valid high for two cycles after byte_taken, so
// byte_valid is masked while the blank counter runs down.
//   clk, rst_n  : clock, asynchronous active-low reset
//   byte_valid  : SPI stage holds a complete byte
//   byte_taken  : 1-cycle pulse, byte consumed (to SPI stage)
//   capture     : strobe to the consumer: spi_rx_data is valid this cycle
module byte_accept_gate (
  input  logic clk,
  input  logic rst_n,
  input  logic byte_valid,
  output logic byte_taken,
  output logic capture
);

  logic [1:0] blank_cnt_q;
  logic [1:0] blank_cnt_d;
  logic       take;

  assign take       = byte_valid && (blank_cnt_q == 2'd0);
  assign byte_taken = take;
  assign capture    = take;

  always_comb begin
    blank_cnt_d = blank_cnt_q;
    if (take) begin
      blank_cnt_d = 2'd2;
    end else if (blank_cnt_q != 2'd0) begin
      blank_cnt_d = blank_cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_cnt_q <= 2'd0;
    end else begin
      blank_cnt_q <= blank_cnt_d;
    end
  end

endmodule

// File: rtl/image_rx_buffer.sv
// Assembles one binary image frame from SPI bytes and hands it to BNN inference.
// A leading opcode selects LOAD (payload follows) or CLEAR; any other opcode
// raises err. The completed frame is held with img_valid until img_taken, with
// rx_enable dropped as back-pressure. A byte gap of TIMEOUT_CYC cycles while
// loading aborts the frame.
// Optional feature: define IMG_RX_CHECKSUM_EN to append an XOR check byte
// after the payload, verified in a CHECK state before the frame is presented.
//   clk, rst_n  : clock, asynchronous active-low reset
//   spi_rx_data : byte from SPI stage, valid while byte_valid
//   byte_valid  : SPI stage holds a byte
//   byte_taken  : 1-cycle pulse, byte consumed
//   rx_enable   : SPI stage may receive (low while a frame waits)
//   img_data    : packed frame, pixel 0 at MSB
//   img_valid   : frame complete, held until img_taken
//   img_taken   : inference accepted the frame
//   busy        : frame load in progress
//   err         : 1-cycle pulse on bad opcode, timeout or checksum mismatch
module image_rx_buffer
  import bnn_ocr_pkg::*;
#(
  parameter int unsigned IMG_BITS    = IMG_BITS_DEFAULT,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          spi_rx_data,
  input  logic                byte_valid,
  output logic                byte_taken,
  output logic                rx_enable,
  output logic [IMG_BITS-1:0] img_data,
  output logic                img_valid,
  input  logic                img_taken,
  output logic                busy,
  output logic                err
);

  localparam int unsigned IMG_BYTES = IMG_BITS / 8;
  localparam int unsigned IdxW      = $clog2(IMG_BYTES);
  localparam int unsigned GapW      = $clog2(TIMEOUT_CYC);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(IMG_BYTES - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(TIMEOUT_CYC - 1);

  img_rx_state_t      state_q, state_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [GapW-1:0]    gap_q, gap_d;
  logic               err_q, err_d;
  logic [IMG_BITS-1:0] img_q;
  logic               img_clear;
  logic               img_wr;
  logic               capture;
`ifdef IMG_RX_CHECKSUM_EN
  logic [7:0]         xor_q, xor_d;
`endif

  byte_accept_gate u_gate (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_valid (byte_valid),
    .byte_taken (byte_taken),
    .capture    (capture)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    err_d     = 1'b0;
    img_clear = 1'b0;
    img_wr    = 1'b0;
`ifdef IMG_RX_CHECKSUM_EN
    xor_d     = xor_q;
`endif

    if (state_q == StLoad || state_q == StCheck) begin
      gap_d = gap_q + GapW'(1);
    end
    // An accept always restarts the gap, even on the expiry cycle.
    if (capture) begin
      gap_d = '0;
    end

    unique case (state_q)
      StIdle: begin
        if (capture) begin
          if (spi_rx_data == OP_LOAD) begin
            state_d = StLoad;
            idx_d   = '0;
`ifdef IMG_RX_CHECKSUM_EN
            xor_d   = 8'h00;
`endif
          end else if (spi_rx_data == OP_CLEAR) begin
            img_clear = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        if (capture) begin
          img_wr = 1'b1;
`ifdef IMG_RX_CHECKSUM_EN
          xor_d  = xor_q ^ spi_rx_data;
`endif
          if (idx_q == IdxLast) begin
`ifdef IMG_RX_CHECKSUM_EN
            state_d = StCheck;
`else
            state_d = StReady;
`endif
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end else if (gap_q == GapLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
          gap_d   = '0;
        end
      end
`ifdef IMG_RX_CHECKSUM_EN
      StCheck: begin
        if (capture) begin
          if (spi_rx_data == xor_q) begin
            state_d = StReady;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end else if (gap_q == GapLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
          gap_d   = '0;
        end
      end
`endif
      StReady: begin
        if (img_taken) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      gap_q   <= '0;
      err_q   <= 1'b0;
`ifdef IMG_RX_CHECKSUM_EN
      xor_q   <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
`ifdef IMG_RX_CHECKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  // Byte k of the payload lands at the MSB end first (pixel 0 at MSB).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_q <= '0;
    end else if (img_clear) begin
      img_q <= '0;
    end else if (img_wr) begin
      img_q[IMG_BITS - 1 - 8 * int'(idx_q) -: 8] <= spi_rx_data;
    end
  end

  assign img_data  = img_q;
  assign img_valid = (state_q == StReady);
  assign rx_enable = (state_q != StReady);
  assign busy      = (state_q == StLoad) || (state_q == StCheck);
  assign err       = err_q;

endmodule

// File: tb/tb_image_rx_buffer.sv
module tb_image_rx_buffer;
  import bnn_ocr_pkg::*;

  localparam int unsigned IB = 1024;
  localparam int unsigned NB = IB / 8;
  localparam int unsigned TO = 200;
`ifdef IMG_RX_CHECKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    spi_rx_data = 8'h00;
  logic          byte_valid = 1'b0;
  logic          byte_taken;
  logic          rx_enable;
  logic [IB-1:0] img_data;
  logic          img_valid;
  logic          img_taken = 1'b0;
  logic          busy;
  logic          err;

  always #5 clk = ~clk;

  image_rx_buffer #(
    .IMG_BITS    (IB),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_rx_data (spi_rx_data),
    .byte_valid  (byte_valid),
    .byte_taken  (byte_taken),
    .rx_enable   (rx_enable),
    .img_data    (img_data),
    .img_valid   (img_valid),
    .img_taken   (img_taken),
    .busy        (busy),
    .err         (err)
  );

  int checks = 0;
  int errors = 0;

  // Event monitor: cycle stamps of takes, errors and img_valid rises.
  int   cyc = 0;
  int   take_cnt = 0;
  int   err_cnt = 0;
  int   last_take = 0;
  int   last_err = 0;
  int   valid_rise = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (byte_taken) begin
      take_cnt  <= take_cnt + 1;
      last_take <= cyc;
    end
    if (err) begin
      err_cnt  <= err_cnt + 1;
      last_err <= cyc;
    end
    if (img_valid && !prev_valid) valid_rise <= cyc;
    prev_valid <= img_valid;
  end

  // Reference model: expected image and running payload XOR.
  logic [IB-1:0] exp_img = '0;
  logic [7:0]    run_xor = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_img(input string tag);
    int k;
    checks++;
    assert (img_data === exp_img) else begin
      errors++;
      k = 0;
      while (k < NB - 1 && img_data[IB-1-8*k -: 8] === exp_img[IB-1-8*k -: 8]) k++;
      $error("FAIL %s: img byte %0d got %h expected %h", tag, k,
             img_data[IB-1-8*k -: 8], exp_img[IB-1-8*k -: 8]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold each byte for 3 cycles, mimicking the SPI stage's lingering byte_valid.
  task automatic send_byte(input logic [7:0] b);
    spi_rx_data = b;
    byte_valid  = 1'b1;
    idle(3);
    byte_valid  = 1'b0;
    spi_rx_data = 8'($urandom);
  endtask

  task automatic send_load();
    send_byte(OP_LOAD);
    run_xor = 8'h00;
  endtask

  // mode 0: byte k = k, mode 1: random, otherwise 0xFF
  task automatic send_payload(input int first, input int n, input int mode, input bit gaps);
    for (int k = first; k < first + n; k++) begin
      logic [7:0] b;
      case (mode)
        0:       b = 8'(k);
        1:       b = 8'($urandom);
        default: b = 8'hFF;
      endcase
      exp_img[IB-1-8*k -: 8] = b;
      run_xor = run_xor ^ b;
      send_byte(b);
      if (gaps) idle($urandom_range(0, 3));
    end
  endtask

  task automatic finish_frame();
`ifdef IMG_RX_CHECKSUM_EN
    send_byte(run_xor);
`endif
  endtask

  task automatic take_frame(input string tag);
    img_taken = 1'b1;
    idle(1);
    img_taken = 1'b0;
    @(negedge clk);
    chk({tag, "_taken_valid"}, 32'(img_valid), 32'd0);
    chk({tag, "_taken_rxen"}, 32'(rx_enable), 32'd1);
    chk_img({tag, "_taken_hold"});
    @(posedge clk);
    #1;
  endtask

  task automatic check_ready(input string tag);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(img_valid), 32'd1);
    chk({tag, "_rxen"}, 32'(rx_enable), 32'd0);
    chk_img({tag, "_img"});
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t0;
    int e0;
    int p0;

    // Reset state
    idle(2);
    @(negedge clk);
    chk("rst_taken", 32'(byte_taken), 32'd0);
    chk("rst_rxen", 32'(rx_enable), 32'd1);
    chk("rst_valid", 32'(img_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk_img("rst_img");
    rst_n = 1'b1;
    idle(2);

    // Sequential frame 0x00..0x7F, one take per byte despite 3-cycle valid
    t0 = take_cnt;
    send_load();
    @(negedge clk);
    chk("t1_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    send_payload(0, NB, 0, 1'b0);
    finish_frame();
    @(negedge clk);
    chk("t1_msb", 32'(img_data[IB-1 -: 8]), 32'h00);
    chk("t1_lsb", 32'(img_data[7:0]), 32'h7F);
    chk("t1_takes", 32'(take_cnt - t0), 32'(1 + NB + EXTRA));
    chk("t1_latency", 32'(valid_rise - last_take), 32'd1);
    chk("t1_err", 32'(err_cnt), 32'd0);
    chk("t1_busy_done", 32'(busy), 32'd0);
    check_ready("t1");
    take_frame("t1");

    // Bad opcode, then clear, then ignored img_taken in IDLE
    e0 = err_cnt;
    send_byte(8'h33);
    @(negedge clk);
    chk("t4_bad_err", 32'(err_cnt - e0), 32'd1);
    chk("t4_bad_lat", 32'(last_err - last_take), 32'd1);
    chk("t4_bad_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    send_byte(OP_CLEAR);
    exp_img = '0;
    @(negedge clk);
    chk_img("t4_clear");
    chk("t4_clear_err", 32'(err_cnt - e0), 32'd1);
    @(posedge clk);
    #1;
    img_taken = 1'b1;
    idle(1);
    img_taken = 1'b0;
    @(negedge clk);
    chk("t4_stray_taken", 32'(img_valid), 32'd0);
    @(posedge clk);
    #1;

    // Random frame with random inter-byte gaps
    send_load();
    send_payload(0, NB, 1, 1'b1);
    finish_frame();
    check_ready("rnd");
    take_frame("rnd");

    // Timeout after 10 bytes
    e0 = err_cnt;
    send_load();
    send_payload(0, 10, 1, 1'b0);
    for (int i = 0; i < int'(TO) + 20 && err_cnt == e0; i++) @(posedge clk);
    @(negedge clk);
    chk("t3_err", 32'(err_cnt - e0), 32'd1);
    chk("t3_gap", 32'(last_err - last_take), 32'(TO + 1));
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_valid", 32'(img_valid), 32'd0);
    chk_img("t3_partial");
    @(posedge clk);
    #1;
    send_load();
    send_payload(0, NB, 1, 1'b0);
    finish_frame();
    check_ready("t3_next");
    take_frame("t3_next");

    // Byte accepted on the expiry cycle wins over the timeout
    e0 = err_cnt;
    send_load();
    send_payload(0, 1, 1, 1'b0);
    p0 = last_take;
    idle(TO - 3);
    send_payload(1, 1, 1, 1'b0);
    @(negedge clk);
    chk("sim_gap", 32'(last_take - p0), 32'(TO));
    chk("sim_noerr", 32'(err_cnt - e0), 32'd0);
    chk("sim_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    send_payload(2, NB - 2, 1, 1'b1);
    finish_frame();
    check_ready("sim");
    take_frame("sim");

`ifdef IMG_RX_CHECKSUM_EN
    // Checksum good and bad
    send_load();
    send_payload(0, NB, 2, 1'b0);
    send_byte(8'h00);
    check_ready("ck_good");
    take_frame("ck_good");
    e0 = err_cnt;
    send_load();
    send_payload(0, NB, 2, 1'b0);
    send_byte(8'h01);
    @(negedge clk);
    chk("ck_bad_err", 32'(err_cnt - e0), 32'd1);
    chk("ck_bad_valid", 32'(img_valid), 32'd0);
    chk("ck_bad_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
`endif

    // Reset in the middle of a frame
    send_load();
    send_payload(0, 64, 1, 1'b0);
    rst_n = 1'b0;
    exp_img = '0;
    #1;
    chk("mrst_valid", 32'(img_valid), 32'd0);
    chk("mrst_rxen", 32'(rx_enable), 32'd1);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk_img("mrst_img");
    idle(2);
    rst_n = 1'b1;
    idle(2);
    send_load();
    send_payload(0, NB, 1, 1'b1);
    finish_frame();
    check_ready("mrst_next");
    take_frame("mrst_next");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
